// File: rtl/wptr_full_ctrl.sv
// ---------------------------------------------------------------------------
// wptr_full_ctrl
// Write-side pointer and full-flag generator for an asynchronous FIFO, living
// entirely in the write clock domain.
//
// Ports:
//   clk              write-domain clock, all state updates on the rising edge
//   rst_n            asynchronous active-low reset
//   winc             write request from the producer
//   rptr_gray_async  read pointer in Gray code, asynchronous to clk
//   waddr            memory write address (low bits of the binary pointer)
//   wen              memory write strobe (combinational)
//   wptr_gray        registered Gray write pointer exported to the read domain
//   wfull            registered full flag
//   wlevel           pessimistic occupancy, 0 .. 2^ADDR_WIDTH
// ---------------------------------------------------------------------------
module wptr_full_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_gray_async,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wen,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic [ADDR_WIDTH:0]   wlevel
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rq1;
    logic [PW-1:0] rq2;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] full_cmp;
    logic          wfull_next;

    // No memory strobe can escape while reset is asserted.
    assign wen = winc & ~wfull & rst_n;

    always_comb begin
        wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wen};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        // Full when the write pointer is exactly one lap ahead of the synced
        // read pointer: in Gray code that means the top two bits inverted.
        full_cmp   = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
        wfull_next = (wgray_next == full_cmp);
    end

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i < PW; i++) begin
            rbin_s[i] = ^(rq2 >> i);
        end
    end

    // Lags real reads by the synchronizer depth, so it can only over-report.
    assign wlevel = wbin - rbin_s;
    assign waddr  = wbin[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin      <= '0;
            wptr_gray <= '0;
            rq1       <= '0;
            rq2       <= '0;
            wfull     <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            // Two-flop synchronizer; rq1 must feed nothing but rq2.
            rq1       <= rptr_gray_async;
            rq2       <= rq1;
            wfull     <= wfull_next;
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
module tb_wptr_full_ctrl;

    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst_n;
    logic          winc;
    logic [AW:0]   rptr;
    logic [AW-1:0] waddr;
    logic          wen;
    logic [AW:0]   wptr_gray;
    logic          wfull;
    logic [AW:0]   wlevel;

    int checks;
    int failures;

    wptr_full_ctrl #(
        .ADDR_WIDTH(AW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .winc            (winc),
        .rptr_gray_async (rptr),
        .waddr           (waddr),
        .wen             (wen),
        .wptr_gray       (wptr_gray),
        .wfull           (wfull),
        .wlevel          (wlevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        winc;
        logic [4:0]  rptr;
        logic        exp_wen;    // sampled after inputs settle, before the edge
        logic [3:0]  exp_waddr;  // remaining fields sampled #1 after the edge
        logic [4:0]  exp_gray;
        logic        exp_full;
        logic [4:0]  exp_level;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    function automatic void add(input logic r, input logic w, input logic [4:0] rp,
                                input logic ew, input logic [3:0] ea, input logic [4:0] eg,
                                input logic ef, input logic [4:0] el);
        vec_t v;
        v.rst_n = r; v.winc = w; v.rptr = rp; v.exp_wen = ew; v.exp_waddr = ea;
        v.exp_gray = eg; v.exp_full = ef; v.exp_level = el;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; winc = 1'b0; rptr = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int k;
    logic [4:0] prev_gray;
    int rb;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; winc = 1'b1; rptr = '0;

        // Reset held with winc=1.
        for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 5'b0, 1'b0, 4'd0, 5'b0, 1'b0, 5'd0);
        // Fill: 16 accepted writes, then a 17th dropped.
        for (int i = 1; i <= 16; i++)
            add(1'b1, 1'b1, 5'b0, 1'b1, 4'(i % 16), gray5(i), (i == 16), 5'(i));
        add(1'b1, 1'b1, 5'b0, 1'b0, 4'd0, 5'b11000, 1'b1, 5'd16);
        // Release: read pointer 0 -> 1, full drops two edges later.
        add(1'b1, 1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b1, 5'd16);
        add(1'b1, 1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b1, 5'd15);
        add(1'b1, 1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b0, 5'd15);
        add(1'b1, 1'b1, 5'b00001, 1'b1, 4'd1, 5'b11001, 1'b1, 5'd16);
        // Read pointer 1 -> 2 to get back to level 15.
        add(1'b1, 1'b0, 5'b00011, 1'b0, 4'd1, 5'b11001, 1'b1, 5'd16);
        add(1'b1, 1'b0, 5'b00011, 1'b0, 4'd1, 5'b11001, 1'b1, 5'd15);
        add(1'b1, 1'b0, 5'b00011, 1'b0, 4'd1, 5'b11001, 1'b0, 5'd15);
        // Near-full race: write and read 2 -> 3 in the same cycle.
        add(1'b1, 1'b1, 5'b00010, 1'b1, 4'd2, 5'b11011, 1'b1, 5'd16);
        add(1'b1, 1'b1, 5'b00010, 1'b0, 4'd2, 5'b11011, 1'b1, 5'd15);
        add(1'b1, 1'b1, 5'b00010, 1'b0, 4'd2, 5'b11011, 1'b0, 5'd15);
        add(1'b1, 1'b0, 5'b00010, 1'b0, 4'd2, 5'b11011, 1'b0, 5'd15);

        // Inputs change on the falling edge, away from the sampling edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; winc = vecs[i].winc; rptr = vecs[i].rptr;
            #1;
            check($sformatf("v%0d wen", i), 32'(wen), 32'(vecs[i].exp_wen));
            @(posedge clk);
            #1;
            check($sformatf("v%0d waddr", i), 32'(waddr), 32'(vecs[i].exp_waddr));
            check($sformatf("v%0d wptr_gray", i), 32'(wptr_gray), 32'(vecs[i].exp_gray));
            check($sformatf("v%0d wfull", i), 32'(wfull), 32'(vecs[i].exp_full));
            check($sformatf("v%0d wlevel", i), 32'(wlevel), 32'(vecs[i].exp_level));
        end

        // Wrap: 40 writes, read pointer trails the write pointer.
        do_reset();
        prev_gray = 5'b0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            winc = 1'b1;
            rptr = gray5((k >= 4) ? k - 4 : 0);
            #1;
            check($sformatf("wrap%0d wen", k), 32'(wen), 32'd1);
            @(posedge clk);
            #1;
            rb = (k >= 5) ? k - 5 : 0;
            check($sformatf("wrap%0d waddr", k), 32'(waddr), 32'(k % 16));
            check($sformatf("wrap%0d wptr_gray", k), 32'(wptr_gray), 32'(gray5(k)));
            check($sformatf("wrap%0d wfull", k), 32'(wfull), 32'd0);
            check($sformatf("wrap%0d wlevel", k), 32'(wlevel), 32'((k - rb) % 32));
            check($sformatf("wrap%0d onebit", k), 32'($countones(wptr_gray ^ prev_gray)), 32'd1);
            prev_gray = wptr_gray;
        end
        @(negedge clk);
        winc = 1'b0;

        // Async reset while full.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            winc = 1'b1; rptr = '0;
        end
        @(posedge clk);
        #1;
        check("prefull wfull", 32'(wfull), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst wfull", 32'(wfull), 32'd0);
        check("arst wptr_gray", 32'(wptr_gray), 32'd0);
        check("arst wlevel", 32'(wlevel), 32'd0);
        check("arst waddr", 32'(waddr), 32'd0);
        check("arst wen", 32'(wen), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; winc = 1'b1;
        #1;
        check("post-arst wen", 32'(wen), 32'd1);
        check("post-arst waddr", 32'(waddr), 32'd0);
        @(posedge clk);
        #1;
        check("post-arst waddr+1", 32'(waddr), 32'd1);
        check("post-arst wptr_gray", 32'(wptr_gray), 32'b00001);
        @(negedge clk);
        winc = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
